// File: rtl/conv1_pkg.sv
// Shared constants and FSM encoding for the conv1 layer and its collector.
// Feature maps are FMAP_W x FMAP_H words of DATA_W raw bits per channel.
package conv1_pkg;

   localparam int DATA_W = 12;
   localparam int FMAP_W = 24;
   localparam int FMAP_H = 24;
   localparam int FMAP_N = FMAP_W * FMAP_H;
   localparam int N_CH   = 3;
   localparam int ADDR_W = 10;

   typedef logic [ADDR_W-1:0] fmap_addr_t;

   localparam fmap_addr_t LAST_ADDR = fmap_addr_t'(FMAP_N - 1);

   typedef enum logic [1:0] {
      COLLECT,
      DONE,
      READ
   } conv1_state_e;

endpackage

// File: rtl/conv1_fmap_ram.sv
// One feature-map channel buffer: 1 write, 1 registered read port.
// Contents are never cleared; only the read register matters downstream.
module conv1_fmap_ram
   import conv1_pkg::*;
(
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [FMAP_N];
   logic [DATA_W-1:0] rdata_q;

   // capture one sample per write strobe
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // synchronous read, holds when not enabled
   always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/conv1_fmap_collector.sv
// Captures a 3-channel conv1 feature map, then replays it channel-major
// through a prefetching valid/ready port with a one-entry skid register.
module conv1_fmap_collector
   import conv1_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] conv_in_1,
   input  logic [DATA_W-1:0] conv_in_2,
   input  logic [DATA_W-1:0] conv_in_3,
   input  logic              valid_in,
   input  logic              rd_start,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_ch,
   output logic [ADDR_W-1:0] out_addr,
   output logic              frame_done,
   output logic              rd_done,
   output logic              overflow,
   output logic              busy
);

   conv1_state_e      state_q;
   fmap_addr_t        wr_cnt_q;
   logic [1:0]        iss_ch_q;
   fmap_addr_t        iss_addr_q;
   logic              pend_q;
   logic [1:0]        tag_ch_q;
   fmap_addr_t        tag_addr_q;
   logic              ov_q, sv_q;
   logic [DATA_W-1:0] od_q, sd_q;
   logic [1:0]        oc_q, sc_q;
   fmap_addr_t        oa_q, sa_q;
   logic              frame_done_q, rd_done_q, overflow_q;

   logic [DATA_W-1:0] wdata [N_CH];
   logic [DATA_W-1:0] rdata [N_CH];
   logic [DATA_W-1:0] ram_q;
   logic [1:0]        held;
   logic              wr_en, pop, space, issue, last_xfer;

   assign wdata[0] = conv_in_1;
   assign wdata[1] = conv_in_2;
   assign wdata[2] = conv_in_3;

   assign wr_en = (state_q == COLLECT) && valid_in;
   assign pop   = ov_q && out_ready;
   assign held  = 2'(ov_q) + 2'(sv_q) + 2'(pend_q);
   assign space = (held < 2'd2) || pop;
   assign issue = ((state_q == DONE) && rd_start)
               || ((state_q == READ) && (iss_ch_q != 2'd3) && space);
   assign last_xfer = pop && (oc_q == 2'd2) && (oa_q == LAST_ADDR);

   for (genvar g = 0; g < N_CH; g++) begin : g_ram
      conv1_fmap_ram u_ram (
         .clk_i   (clk),
         .we_i    (wr_en),
         .waddr_i (wr_cnt_q),
         .wdata_i (wdata[g]),
         .re_i    (issue),
         .raddr_i (iss_addr_q),
         .rdata_o (rdata[g])
      );
   end

   // pick the channel whose read is returning this cycle
   always_comb begin
      ram_q = rdata[0];
      case (tag_ch_q)
         2'd1:    ram_q = rdata[1];
         2'd2:    ram_q = rdata[2];
         default: ram_q = rdata[0];
      endcase
   end

   // frame FSM, write counter, replay address issue and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= COLLECT;
         wr_cnt_q     <= '0;
         iss_ch_q     <= '0;
         iss_addr_q   <= '0;
         frame_done_q <= 1'b0;
         rd_done_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         rd_done_q    <= 1'b0;
         if (valid_in && (state_q != COLLECT)) overflow_q <= 1'b1;
         unique case (state_q)
            COLLECT: begin
               if (valid_in) begin
                  if (wr_cnt_q == LAST_ADDR) begin
                     wr_cnt_q     <= '0;
                     state_q      <= DONE;
                     frame_done_q <= 1'b1;
                  end else begin
                     wr_cnt_q <= wr_cnt_q + fmap_addr_t'(1);
                  end
               end
            end
            DONE: begin
               if (rd_start) state_q <= READ;
            end
            READ: begin
               if (last_xfer) begin
                  state_q   <= COLLECT;
                  rd_done_q <= 1'b1;
               end
            end
            default: state_q <= COLLECT;
         endcase
         if (issue) begin
            if (iss_addr_q == LAST_ADDR) begin
               iss_addr_q <= '0;
               iss_ch_q   <= iss_ch_q + 2'd1;
            end else begin
               iss_addr_q <= iss_addr_q + fmap_addr_t'(1);
            end
         end
         if (last_xfer) begin
            iss_ch_q   <= '0;
            iss_addr_q <= '0;
         end
      end
   end

   // returning RAM word goes to the output register, or to skid if stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q     <= 1'b0;
         tag_ch_q   <= '0;
         tag_addr_q <= '0;
         ov_q       <= 1'b0;
         od_q       <= '0;
         oc_q       <= '0;
         oa_q       <= '0;
         sv_q       <= 1'b0;
         sd_q       <= '0;
         sc_q       <= '0;
         sa_q       <= '0;
      end else begin
         pend_q <= issue;
         if (issue) begin
            tag_ch_q   <= iss_ch_q;
            tag_addr_q <= iss_addr_q;
         end
         if (!ov_q || pop) begin
            if (sv_q) begin
               ov_q <= 1'b1;
               od_q <= sd_q;
               oc_q <= sc_q;
               oa_q <= sa_q;
               sv_q <= pend_q;
               if (pend_q) begin
                  sd_q <= ram_q;
                  sc_q <= tag_ch_q;
                  sa_q <= tag_addr_q;
               end
            end else if (pend_q) begin
               ov_q <= 1'b1;
               od_q <= ram_q;
               oc_q <= tag_ch_q;
               oa_q <= tag_addr_q;
            end else begin
               ov_q <= 1'b0;
            end
         end else if (pend_q) begin
            sv_q <= 1'b1;
            sd_q <= ram_q;
            sc_q <= tag_ch_q;
            sa_q <= tag_addr_q;
         end
      end
   end

   assign out_valid  = ov_q;
   assign out_data   = od_q;
   assign out_ch     = oc_q;
   assign out_addr   = oa_q;
   assign frame_done = frame_done_q;
   assign rd_done    = rd_done_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q != COLLECT);

endmodule
